branch_resolve_ctrl: RTL and testbench
======================================

# branch_resolve_ctrl

Sequencer for the branch-compare datapath. Accepts one branch at a time from decode and issues a register-file read for the compare operand. It compares the zero-extended 5-bit RS value against the returned 32-bit word and emits a one-cycle resolution with PC redirect and flush. It sits between decode, the register-file read port, and PC/fetch control, and stalls decode while a branch is in flight.

## Interface
- TIMEOUT, default 8: maximum cycles in WAIT for `rf_rd_valid` before forced resolution.
- CNT_W, default 16: width of the saturating statistics counters.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- br_valid  in  1  decode offers a branch.
- br_ready  out  1  controller can accept; a branch is accepted when `br_valid && br_ready`.
- opc_in  in  20  branch opcode; bit 14 set means compare-branch.
- rs_val  in  5  RS value, zero-extended to 32 bits for the compare.
- rf_addr  in  5  register holding the compare operand.
- target_in  in  32  branch target PC.
- rf_rd_en  out  1  one-cycle read request.
- rf_rd_addr  out  5  latched `rf_addr`.
- rf_rd_valid  in  1  read data valid.
- rf_rd_data  in  32  read data.
- res_valid  out  1  one-cycle resolution pulse.
- res_taken  out  1  resolution result; meaningful only while `res_valid`.
- pc_redirect  out  1  equals `res_valid && res_taken`.
- pc_target  out  32  latched target; meaningful while `pc_redirect`.
- flush  out  1  equals `pc_redirect`.
- stall  out  1  high whenever state is not IDLE.
- err_timeout  out  1  one-cycle pulse coinciding with a timeout resolution.
- taken_cnt  out  CNT_W  saturating count of taken branches.
- ntaken_cnt  out  CNT_W  saturating count of not-taken branches.

## Operation
- The FSM has four states: IDLE, RD_REQ, WAIT, RESOLVE.
- IDLE:
  - `br_ready = 1`.
  - On accept, latch `opc_in`, `rs_val`, `rf_addr`, `target_in`.
  - If `opc_in[14]`, go to RD_REQ.
  - Otherwise go to RESOLVE with `taken = 0`; no RF read is issued.
- RD_REQ: `rf_rd_en = 1` for exactly one cycle, then go to WAIT and clear the wait counter.
- WAIT:
  - If `rf_rd_valid`, latch `taken = ({27'b0, rs_q} == rf_rd_data)` and go to RESOLVE.
  - Otherwise increment the wait counter.
  - When the counter reaches TIMEOUT-1 without valid, set `taken = 0`, flag a timeout, and go to RESOLVE.
  - Valid arriving on that same cycle wins; no timeout is flagged.
- RESOLVE:
  - Drive `res_valid`; drive `err_timeout` if a timeout was flagged.
  - Increment `taken_cnt` or `ntaken_cnt`, saturating at all-ones.
  - Return to IDLE.
- `rf_rd_valid` outside WAIT is ignored, including a late response after a timeout.
- Reset, including mid-operation:
  - State goes to IDLE; any pending read is abandoned.
  - All outputs go to 0 except `br_ready`, which is 0 while `rst` is high and 1 in the cycle after.
  - Counters, the timeout flag and all latched fields are cleared.

## Timing
- Compare-branch, accepted in cycle 0:
  - `rf_rd_en` in cycle 1.
  - Earliest `rf_rd_valid` in cycle 2.
  - `res_valid` in cycle 3.
  - `br_ready` back high in cycle 4.
  - `stall` is high in cycles 1–3.
- Non-compare branch, accepted in cycle 0: `res_valid` in cycle 1, `br_ready` in cycle 2.
- Timeout, with WAIT entered in cycle 2: resolution pulse in cycle 2+TIMEOUT.
- All outputs are registered-state decodes; there is no combinational path from `br_valid` or `rf_rd_data` to any output.
- Back-to-back branches: at most one accept per IDLE visit. Minimum spacing is 4 cycles for a compare branch and 2 cycles for a non-compare branch.

## Structure
- Shared package holds:
  - the state encoding (2-bit localparams);
  - `OPC_CMP_BIT = 14`;
  - the 32-bit data width constant.
- Sub-module `branch_cmp`: combinational zero-extend-and-compare of 5-bit RS against 32-bit data, producing one equality bit. The WAIT state instantiates it.
- Wait counter width: `$clog2(TIMEOUT)`. The counters live in the top module.

## Test plan
- Compare match: opc bit14=1, rs_val=5'h0A, rf_rd_data=32'h0000000A with valid in cycle 2 -> cycle 3 `res_valid=1`, `res_taken=1`, `pc_redirect=1`, `flush=1`, `pc_target=target_in`; `taken_cnt=1`.
- Upper-bit mismatch: rs_val=5'h0A, rf_rd_data=32'h0001000A -> `res_taken=0`, no redirect; `ntaken_cnt=1`.
- Non-compare branch: opc bit14=0 -> no `rf_rd_en`; cycle 1 `res_valid=1`, `res_taken=0`.
- Timeout: TIMEOUT=8, `rf_rd_valid` never asserted -> `res_valid` and `err_timeout` in cycle 10, not taken. A valid in cycle 11 is ignored and the counters are unchanged.
- Reset in WAIT: `rst` in cycle 2 -> cycle 3 state IDLE, all outputs 0, counters 0. A valid in cycle 3 is ignored; `br_ready=1` from cycle 3.
- Saturation: CNT_W=2, five taken branches -> `taken_cnt=3`.

Source files
------------

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the branch-compare sequencer: state encoding,
// operand widths and the RS zero-extension helper.
package branch_resolve_ctrl_pkg;

  localparam int DATA_W      = 32;
  localparam int RS_W        = 5;
  localparam int ADDR_W      = 5;
  localparam int OPC_W       = 20;
  localparam int OPC_CMP_BIT = 14;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_RESOLVE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_RD_REQ  = ST_RD_REQ,
    S_WAIT    = ST_WAIT,
    S_RESOLVE = ST_RESOLVE
  } state_e;

  // RS is an unsigned 5-bit immediate; widen it to the register data width.
  function automatic logic [DATA_W-1:0] zext_rs(input logic [RS_W-1:0] rs);
    return {{(DATA_W-RS_W){1'b0}}, rs};
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_cmp.sv
// Combinational equality of the zero-extended RS value against a
// register-file word.
module branch_cmp
  import branch_resolve_ctrl_pkg::*;
(
  input  logic [RS_W-1:0]   rs,
  input  logic [DATA_W-1:0] data,
  output logic              eq
);

  // Upper 27 bits of the word must be zero for a match.
  assign eq = (zext_rs(rs) == data);

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer: accepts one branch from decode, optionally
// reads the compare operand from the register file, and produces a
// one-cycle resolution with redirect/flush plus taken/not-taken statistics.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               br_valid,
  output logic               br_ready,
  input  logic [OPC_W-1:0]   opc_in,
  input  logic [RS_W-1:0]    rs_val,
  input  logic [ADDR_W-1:0]  rf_addr,
  input  logic [DATA_W-1:0]  target_in,
  output logic               rf_rd_en,
  output logic [ADDR_W-1:0]  rf_rd_addr,
  input  logic               rf_rd_valid,
  input  logic [DATA_W-1:0]  rf_rd_data,
  output logic               res_valid,
  output logic               res_taken,
  output logic               pc_redirect,
  output logic [DATA_W-1:0]  pc_target,
  output logic               flush,
  output logic               stall,
  output logic               err_timeout,
  output logic [CNT_W-1:0]   taken_cnt,
  output logic [CNT_W-1:0]   ntaken_cnt
);

  localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [OPC_W-1:0]    opc_q, opc_d;
  logic [RS_W-1:0]     rs_q, rs_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   target_q, target_d;
  logic                taken_q, taken_d;
  logic                tmo_q, tmo_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [CNT_W-1:0]    taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0]    ntaken_cnt_q, ntaken_cnt_d;
  logic                rs_match;
  logic                opc_unused;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Only the compare bit steers control; the rest of the opcode is kept
  // for completeness of the latched branch record.
  assign opc_unused = ^opc_q;

  branch_cmp u_cmp (
    .rs   (rs_q),
    .data (rf_rd_data),
    .eq   (rs_match)
  );

  // Next-state and latched-field update for the four-state sequencer.
  always_comb begin
    state_d      = state_q;
    opc_d        = opc_q;
    rs_d         = rs_q;
    addr_d       = addr_q;
    target_d     = target_q;
    taken_d      = taken_q;
    tmo_d        = tmo_q;
    wcnt_d       = wcnt_q;
    taken_cnt_d  = taken_cnt_q;
    ntaken_cnt_d = ntaken_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (br_valid) begin
          opc_d    = opc_in;
          rs_d     = rs_val;
          addr_d   = rf_addr;
          target_d = target_in;
          taken_d  = 1'b0;
          tmo_d    = 1'b0;
          state_d  = opc_in[OPC_CMP_BIT] ? S_RD_REQ : S_RESOLVE;
        end
      end
      S_RD_REQ: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A response on the final wait cycle still resolves normally.
        if (rf_rd_valid) begin
          taken_d = rs_match;
          state_d = S_RESOLVE;
        end else if (wcnt_q == WAIT_LAST) begin
          taken_d = 1'b0;
          tmo_d   = 1'b1;
          state_d = S_RESOLVE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_RESOLVE: begin
        if (taken_q) taken_cnt_d  = sat_inc(taken_cnt_q);
        else         ntaken_cnt_d = sat_inc(ntaken_cnt_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched-field registers; reset abandons any branch in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      opc_q        <= '0;
      rs_q         <= '0;
      addr_q       <= '0;
      target_q     <= '0;
      taken_q      <= 1'b0;
      tmo_q        <= 1'b0;
      wcnt_q       <= '0;
      taken_cnt_q  <= '0;
      ntaken_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      opc_q        <= opc_d;
      rs_q         <= rs_d;
      addr_q       <= addr_d;
      target_q     <= target_d;
      taken_q      <= taken_d;
      tmo_q        <= tmo_d;
      wcnt_q       <= wcnt_d;
      taken_cnt_q  <= taken_cnt_d;
      ntaken_cnt_q <= ntaken_cnt_d;
    end
  end

  // Outputs decode registered state only; ready is held low during reset.
  assign br_ready    = (state_q == S_IDLE) && !rst;
  assign stall       = (state_q != S_IDLE);
  assign rf_rd_en    = (state_q == S_RD_REQ);
  assign rf_rd_addr  = addr_q;
  assign res_valid   = (state_q == S_RESOLVE);
  assign res_taken   = res_valid && taken_q;
  assign pc_redirect = res_taken;
  assign flush       = pc_redirect;
  assign pc_target   = pc_redirect ? target_q : '0;
  assign err_timeout = res_valid && tmo_q;
  assign taken_cnt   = taken_cnt_q;
  assign ntaken_cnt  = ntaken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed scenarios followed
// by randomized branches against a per-branch timing/outcome model.
module tb_branch_resolve_ctrl;

  localparam int T    = 8;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          br_valid;
  logic          br_ready;
  logic [19:0]   opc_in;
  logic [4:0]    rs_val;
  logic [4:0]    rf_addr;
  logic [31:0]   target_in;
  logic          rf_rd_en;
  logic [4:0]    rf_rd_addr;
  logic          rf_rd_valid;
  logic [31:0]   rf_rd_data;
  logic          res_valid;
  logic          res_taken;
  logic          pc_redirect;
  logic [31:0]   pc_target;
  logic          flush;
  logic          stall;
  logic          err_timeout;
  logic [CW-1:0] taken_cnt;
  logic [CW-1:0] ntaken_cnt;

  int checks = 0;
  int errors = 0;
  int exp_t  = 0;
  int exp_n  = 0;

  branch_resolve_ctrl #(.TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(br_ready),
    .opc_in(opc_in), .rs_val(rs_val), .rf_addr(rf_addr), .target_in(target_in),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_valid(rf_rd_valid),
    .rf_rd_data(rf_rd_data), .res_valid(res_valid), .res_taken(res_taken),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .flush(flush),
    .stall(stall), .err_timeout(err_timeout), .taken_cnt(taken_cnt),
    .ntaken_cnt(ntaken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // One branch, starting at a falling edge with the DUT idle. d is the
  // response delay in cycles after the read request (beyond T = never).
  task automatic run_br(input bit cmp, input logic [4:0] rs, input logic [4:0] addr,
                        input logic [31:0] tgt, input int d, input logic [31:0] data,
                        input bit v0, input bit noise);
    logic [31:0] zx;
    bit taken, tmo;
    int r;
    zx    = {27'b0, rs};
    tmo   = cmp && (d > T);
    taken = cmp && !tmo && (data == zx);
    r     = !cmp ? 1 : (tmo ? 2 + T : 2 + d);

    chk("accept_ready", br_ready, 1);
    chk("accept_stall", stall, 0);
    br_valid    = 1'b1;
    opc_in      = 20'($urandom);
    opc_in[14]  = cmp;
    rs_val      = rs;
    rf_addr     = addr;
    target_in   = tgt;
    rf_rd_valid = v0;
    rf_rd_data  = zx;

    for (int k = 1; k <= r + 1; k++) begin
      @(negedge clk);
      chk("rf_rd_en", rf_rd_en, (cmp && k == 1));
      if (cmp && k == 1) chk("rf_rd_addr", rf_rd_addr, addr);
      chk("stall", stall, (k <= r));
      chk("br_ready", br_ready, (k == r + 1));
      chk("res_valid", res_valid, (k == r));
      if (k == r) chk("res_taken", res_taken, taken);
      chk("pc_redirect", pc_redirect, (k == r) && taken);
      chk("flush", flush, (k == r) && taken);
      if (k == r && taken) chk("pc_target", pc_target, tgt);
      chk("err_timeout", err_timeout, (k == r) && tmo);
      chk("taken_cnt", taken_cnt, exp_t);
      chk("ntaken_cnt", ntaken_cnt, exp_n);
      if (k == r) begin
        if (taken) exp_t = sat(exp_t);
        else       exp_n = sat(exp_n);
      end
      if (k <= r) begin
        br_valid  = 1'($urandom_range(0, 1));
        opc_in    = 20'($urandom);
        rs_val    = 5'($urandom);
        rf_addr   = 5'($urandom);
        target_in = $urandom;
        if (cmp && k == 1 + d) begin
          rf_rd_valid = 1'b1;
          rf_rd_data  = data;
        end else if (noise && (k == 1 || k == r)) begin
          rf_rd_valid = 1'b1;
          rf_rd_data  = zx;
        end else begin
          rf_rd_valid = 1'b0;
          rf_rd_data  = $urandom;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; br_valid = 1'b0; opc_in = '0; rs_val = '0; rf_addr = '0;
    target_in = '0; rf_rd_valid = 1'b0; rf_rd_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready_low", br_ready, 0);
    chk("rst_stall", stall, 0);
    chk("rst_res_valid", res_valid, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", br_ready, 1);
    chk("post_rst_taken_cnt", taken_cnt, 0);
    chk("post_rst_ntaken_cnt", ntaken_cnt, 0);
    chk("post_rst_rd_en", rf_rd_en, 0);

    // Compare match, earliest response
    run_br(1, 5'h0A, 5'h07, 32'h8000_1000, 1, 32'h0000_000A, 0, 0);
    chk("match_taken_cnt", taken_cnt, 1);
    // Upper-bit mismatch
    run_br(1, 5'h0A, 5'h07, 32'h8000_2000, 1, 32'h0001_000A, 0, 0);
    chk("mismatch_ntaken_cnt", ntaken_cnt, 1);
    // Non-compare, back-to-back
    run_br(0, 5'h11, 5'h02, 32'h0000_4000, 1, 32'h0, 0, 1);
    // Timeout, then a late response in the following idle cycle
    run_br(1, 5'h03, 5'h1F, 32'hDEAD_0000, 100, 32'h3, 0, 1);
    run_br(1, 5'h05, 5'h04, 32'hCAFE_0000, 3, 32'h5, 1, 1);
    // Response on the last wait cycle beats the timeout
    run_br(1, 5'h1C, 5'h09, 32'h1234_5678, T, 32'h1C, 0, 0);
    run_br(1, 5'h1C, 5'h09, 32'h1234_9999, T + 1, 32'h1C, 0, 0);

    // Reset while waiting for the register file
    br_valid = 1'b1; opc_in = 20'h04000; rs_val = 5'h0A; rf_addr = 5'h03;
    target_in = 32'h0000_1234; rf_rd_valid = 1'b0;
    @(negedge clk);
    br_valid = 1'b0;
    chk("rstw_rd_en", rf_rd_en, 1);
    @(negedge clk);
    chk("rstw_stall", stall, 1);
    rst = 1'b1;
    #1 chk("rstw_ready_low", br_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    exp_t = 0; exp_n = 0;
    chk("rstw_idle_stall", stall, 0);
    chk("rstw_idle_ready", br_ready, 1);
    chk("rstw_res_valid", res_valid, 0);
    chk("rstw_rd_en0", rf_rd_en, 0);
    chk("rstw_rd_addr", rf_rd_addr, 0);
    chk("rstw_pc_target", pc_target, 0);
    chk("rstw_flush", flush, 0);
    chk("rstw_err", err_timeout, 0);
    chk("rstw_taken_cnt", taken_cnt, 0);
    chk("rstw_ntaken_cnt", ntaken_cnt, 0);
    rf_rd_valid = 1'b1; rf_rd_data = 32'h0000_000A;
    @(negedge clk);
    rf_rd_valid = 1'b0;
    chk("rstw_late_res", res_valid, 0);
    chk("rstw_late_stall", stall, 0);
    chk("rstw_late_ready", br_ready, 1);
    chk("rstw_late_cnt", taken_cnt, 0);

    // Saturation of the taken counter
    for (int i = 0; i < 5; i++)
      run_br(1, 5'(i + 1), 5'(i), 32'h100 * i, 1, 32'(i + 1), 0, 0);
    chk("sat_taken_cnt", taken_cnt, 3);

    // Randomized branches
    for (int i = 0; i < 60; i++) begin
      bit c;
      logic [4:0] rs;
      logic [31:0] dat;
      c  = 1'($urandom_range(0, 3) != 0);
      rs = 5'($urandom);
      case ($urandom_range(0, 2))
        0:       dat = {27'b0, rs};
        1:       dat = {27'b0, rs} ^ (32'h1 << $urandom_range(0, 31));
        default: dat = $urandom;
      endcase
      run_br(c, rs, 5'($urandom), $urandom, $urandom_range(1, T + 3), dat,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    br_valid = 1'b0; rf_rd_valid = 1'b0;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
